sub_nbits_seq: RTL and testbench

//  Parametrised multi-cycle subtractor for the ULA: computes T = A - B over WIDTH bits, DIGIT bits per clock.

---
 rtl/sub_pkg.sv | 31 +++
 rtl/sub_digit.sv | 35 +++
 rtl/sub_nbits_seq.sv | 151 +++++++++++++++
 tb/tb_sub_nbits_seq.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// ---------------------------------------------------------------------------
// sub_pkg
// Shared definitions for the sequential ULA subtractor.
//   state_t      : controller states (IDLE, RUN, DONE)
//   FLAG_*       : bit positions inside the registered status-flag vector
//   steps()      : number of digit steps needed for a WIDTH-bit operation
//   stepBits()   : width of the step counter for a given step count
// ---------------------------------------------------------------------------
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int FLAG_BORROW = 0;
    localparam int FLAG_OVF    = 1;
    localparam int NUM_FLAGS   = 2;

    function automatic int steps(input int width, input int digit);
        return width / digit;
    endfunction

    // A single-step configuration still needs a 1-bit counter so the
    // declaration never collapses to zero width.
    function automatic int stepBits(input int stepCount);
        return (stepCount < 2) ? 1 : $clog2(stepCount);
    endfunction

endpackage

// File: rtl/sub_digit.sv
// ---------------------------------------------------------------------------
// sub_digit
// Combinational ripple of DIGIT full-subtractor cells computing
// i_x - i_y - i_bin over one digit.
// Ports:
//   i_x    [DIGIT-1:0]  minuend digit
//   i_y    [DIGIT-1:0]  subtrahend digit
//   i_bin               borrow into the least significant cell
//   o_d    [DIGIT-1:0]  difference digit
//   o_bout              borrow out of the most significant cell
// ---------------------------------------------------------------------------
module sub_digit #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] i_x,
    input  logic [DIGIT-1:0] i_y,
    input  logic             i_bin,
    output logic [DIGIT-1:0] o_d,
    output logic             o_bout
);

    logic [DIGIT:0] w_borrow;

    assign w_borrow[0] = i_bin;

    // Each cell borrows when x < y, or when x == y and a borrow arrives
    // from the cell below.
    for (genvar g = 0; g < DIGIT; g++) begin : g_cell
        assign o_d[g]         = i_x[g] ^ i_y[g] ^ w_borrow[g];
        assign w_borrow[g+1]  = (~i_x[g] & i_y[g]) | (~(i_x[g] ^ i_y[g]) & w_borrow[g]);
    end

    assign o_bout = w_borrow[DIGIT];

endmodule

// File: rtl/sub_nbits_seq.sv
// ---------------------------------------------------------------------------
// sub_nbits_seq
// Multi-cycle subtractor for the ULA: T = A - B over WIDTH bits, processing
// DIGIT bits per clock with a start/done handshake. A single sub_digit slice
// is reused on every step; partial results are collected in a shadow
// register so the visible result only changes when a whole operation ends.
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  request, sampled only while idle
//   a, b   [WIDTH-1:0] minuend / subtrahend, captured on accepted start
//   en     output enable, gates t/flag/ovf/zero combinationally
//   busy   high while digits are being processed
//   done   one-cycle pulse when a new result becomes valid
//   t      [WIDTH-1:0] difference modulo 2^WIDTH
//   flag   final borrow (a < b unsigned)
//   ovf    signed overflow of a - b
//   zero   difference equals zero
// ---------------------------------------------------------------------------
module sub_nbits_seq
    import sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             en,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] t,
    output logic             flag,
    output logic             ovf,
    output logic             zero
);

    localparam int STEPS  = steps(WIDTH, DIGIT);
    localparam int STEP_W = stepBits(STEPS);

    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_paramCheck
        $error("sub_nbits_seq: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    state_t               r_state;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_shadow;
    logic [WIDTH-1:0]     r_result;
    logic [STEP_W-1:0]    r_step;
    logic                 r_borrow;
    logic [NUM_FLAGS-1:0] r_flags;
    logic                 r_busy;
    logic                 r_done;

    logic [DIGIT-1:0]     w_x;
    logic [DIGIT-1:0]     w_y;
    logic [DIGIT-1:0]     w_d;
    logic                 w_bout;
    logic [WIDTH-1:0]     w_shadowNext;
    logic                 w_lastStep;
    logic                 w_ovf;

    // Select the current digit of both latched operands and merge the
    // freshly computed difference digit into a copy of the shadow register.
    // On the last step w_shadowNext is the complete result, which is also
    // what the overflow flag must look at.
    always_comb begin
        w_x          = r_a[int'(r_step)*DIGIT +: DIGIT];
        w_y          = r_b[int'(r_step)*DIGIT +: DIGIT];
        w_shadowNext = r_shadow;
        w_shadowNext[int'(r_step)*DIGIT +: DIGIT] = w_d;
        w_lastStep   = (r_step == STEP_W'(STEPS - 1));
        w_ovf        = (r_a[WIDTH-1] ^ r_b[WIDTH-1]) & (r_a[WIDTH-1] ^ w_shadowNext[WIDTH-1]);
    end

    sub_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .i_x    (w_x),
        .i_y    (w_y),
        .i_bin  (r_borrow),
        .o_d    (w_d),
        .o_bout (w_bout)
    );

    // Controller and datapath registers. busy and done are registered
    // alongside the state so they change exactly on state transitions.
    // The visible result and flags are written only when entering DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_shadow <= '0;
            r_result <= '0;
            r_step   <= '0;
            r_borrow <= 1'b0;
            r_flags  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_shadow <= '0;
                        r_step   <= '0;
                        r_borrow <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_shadow <= w_shadowNext;
                    r_borrow <= w_bout;
                    r_step   <= r_step + STEP_W'(1);
                    if (w_lastStep) begin
                        r_result              <= w_shadowNext;
                        r_flags[FLAG_BORROW]  <= w_bout;
                        r_flags[FLAG_OVF]     <= w_ovf;
                        r_busy                <= 1'b0;
                        r_done                <= 1'b1;
                        r_state               <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign t    = en ? r_result : '0;
    assign flag = en & r_flags[FLAG_BORROW];
    assign ovf  = en & r_flags[FLAG_OVF];
    assign zero = en & ~(|r_result);

endmodule

// File: tb/tb_sub_nbits_seq.sv
// ---------------------------------------------------------------------------
// tb_sub_nbits_seq
// Directed bench for sub_nbits_seq. Two instances share clock and reset:
// dut8 (WIDTH=8, DIGIT=2) and dut16 (WIDTH=16, DIGIT=16, single step).
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_sub_nbits_seq;

    logic        clk;
    logic        rst;

    logic        start8, en8;
    logic [7:0]  a8, b8, t8;
    logic        busy8, done8, flag8, ovf8, zero8;

    logic        start16, en16;
    logic [15:0] a16, b16, t16;
    logic        busy16, done16, flag16, ovf16, zero16;

    int total = 0;
    int bad   = 0;

    sub_nbits_seq #(.WIDTH(8), .DIGIT(2)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .en(en8),
        .busy(busy8), .done(done8), .t(t8), .flag(flag8), .ovf(ovf8), .zero(zero8)
    );

    sub_nbits_seq #(.WIDTH(16), .DIGIT(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .en(en16),
        .busy(busy16), .done(done16), .t(t16), .flag(flag16), .ovf(ovf16), .zero(zero16)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Issue one operation on dut8 and return the number of falling edges
    // from the start request until done is seen (-1 if it never comes).
    // Operands are scrambled right after acceptance.
    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, output int lat);
        @(negedge clk);
        start8 = 1'b1; a8 = av; b8 = bv;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start8 = 1'b0; a8 = ~av; b8 = ~bv;
            end
            if (done8 === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    // Same for the single-step dut16.
    task automatic applyStimulus16(input logic [15:0] av, input logic [15:0] bv, output int lat);
        @(negedge clk);
        start16 = 1'b1; a16 = av; b16 = bv;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start16 = 1'b0; a16 = ~av; b16 = ~bv;
            end
            if (done16 === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start8 = 1'b0; en8 = 1'b1; a8 = 8'h00; b8 = 8'h00;
        start16 = 1'b0; en16 = 1'b1; a16 = 16'h0; b16 = 16'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        total++; if (busy8 !== 1'b0)  begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy8); end
        total++; if (done8 !== 1'b0)  begin bad++; $display("[TB] FAIL reset_done: got %b want 0", done8); end
        total++; if (t8 !== 8'h00)    begin bad++; $display("[TB] FAIL reset_t: got %h want 00", t8); end
        total++; if (flag8 !== 1'b0)  begin bad++; $display("[TB] FAIL reset_flag: got %b want 0", flag8); end
        total++; if (ovf8 !== 1'b0)   begin bad++; $display("[TB] FAIL reset_ovf: got %b want 0", ovf8); end
        total++; if (zero8 !== 1'b1)  begin bad++; $display("[TB] FAIL reset_zero: got %b want 1", zero8); end
        total++; if (t16 !== 16'h0 || zero16 !== 1'b1 || busy16 !== 1'b0)
            begin bad++; $display("[TB] FAIL reset_dut16: got t=%h zero=%b busy=%b want 0000/1/0", t16, zero16, busy16); end
    endtask

    task automatic test_basic();
        int  lat;
        logic busyOk;
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h50; b8 = 8'h20;
        lat = -1; busyOk = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
            end
            if (done8 === 1'b1) begin
                lat = c;
                break;
            end
            if (busy8 !== 1'b1) busyOk = 1'b0;
        end
        total++; if (lat != 5)        begin bad++; $display("[TB] FAIL basic_latency: got %0d want 5", lat); end
        total++; if (busyOk !== 1'b1) begin bad++; $display("[TB] FAIL basic_busy_run: got low want high for 4 cycles"); end
        total++; if (busy8 !== 1'b0)  begin bad++; $display("[TB] FAIL basic_busy_done: got %b want 0", busy8); end
        total++; if (t8 !== 8'h30 || flag8 !== 1'b0 || ovf8 !== 1'b0 || zero8 !== 1'b0)
            begin bad++; $display("[TB] FAIL basic_result: got t=%h f=%b o=%b z=%b want 30/0/0/0", t8, flag8, ovf8, zero8); end
        @(negedge clk);
        total++; if (done8 !== 1'b0)  begin bad++; $display("[TB] FAIL basic_done_pulse: got %b want 0", done8); end
    endtask

    typedef struct {
        logic [7:0] a, b, t;
        logic f, o, z;
    } vec_t;

    task automatic test_vectors();
        vec_t vecs[5];
        int   lat;
        vecs[0] = '{a: 8'h10, b: 8'h20, t: 8'hF0, f: 1'b1, o: 1'b0, z: 1'b0};
        vecs[1] = '{a: 8'h80, b: 8'h01, t: 8'h7F, f: 1'b0, o: 1'b1, z: 1'b0};
        vecs[2] = '{a: 8'hA5, b: 8'hA5, t: 8'h00, f: 1'b0, o: 1'b0, z: 1'b1};
        vecs[3] = '{a: 8'h7F, b: 8'hFF, t: 8'h80, f: 1'b1, o: 1'b1, z: 1'b0};
        vecs[4] = '{a: 8'h03, b: 8'h04, t: 8'hFF, f: 1'b1, o: 1'b0, z: 1'b0};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, lat);
            total++;
            if (lat != 5 || t8 !== vecs[i].t || flag8 !== vecs[i].f || ovf8 !== vecs[i].o || zero8 !== vecs[i].z) begin
                bad++;
                $display("[TB] FAIL vector_%0d: got lat=%0d t=%h f=%b o=%b z=%b want 5 %h/%b/%b/%b",
                         i, lat, t8, flag8, ovf8, zero8, vecs[i].t, vecs[i].f, vecs[i].o, vecs[i].z);
            end
        end
    endtask

    task automatic test_enable();
        int lat;
        applyStimulus(8'h00, 8'h80, lat);
        @(negedge clk);
        en8 = 1'b0;
        #1;
        total++; if (t8 !== 8'h00 || flag8 !== 1'b0 || ovf8 !== 1'b0 || zero8 !== 1'b0)
            begin bad++; $display("[TB] FAIL enable_off: got t=%h f=%b o=%b z=%b want 00/0/0/0", t8, flag8, ovf8, zero8); end
        en8 = 1'b1;
        #1;
        total++; if (t8 !== 8'h80 || flag8 !== 1'b1 || ovf8 !== 1'b1 || zero8 !== 1'b0)
            begin bad++; $display("[TB] FAIL enable_on: got t=%h f=%b o=%b z=%b want 80/1/1/0", t8, flag8, ovf8, zero8); end
        en8 = 1'b0;
        applyStimulus(8'h50, 8'h20, lat);
        total++; if (lat != 5 || t8 !== 8'h00)
            begin bad++; $display("[TB] FAIL enable_fsm_gated: got lat=%0d t=%h want 5 00", lat, t8); end
        en8 = 1'b1;
        #1;
        total++; if (t8 !== 8'h30) begin bad++; $display("[TB] FAIL enable_restore: got %h want 30", t8); end
    endtask

    task automatic test_restart_ignored();
        int lat;
        int extra;
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h50; b8 = 8'h20;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) start8 = 1'b0;
            if (c == 2) begin
                start8 = 1'b1; a8 = 8'h11; b8 = 8'h99;
            end
            if (c == 3) start8 = 1'b0;
            if (done8 === 1'b1) begin
                lat = c;
                break;
            end
        end
        total++; if (lat != 5 || t8 !== 8'h30)
            begin bad++; $display("[TB] FAIL restart_ignored: got lat=%0d t=%h want 5 30", lat, t8); end
        extra = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done8 === 1'b1 || busy8 === 1'b1) extra++;
        end
        total++; if (extra != 0) begin bad++; $display("[TB] FAIL restart_no_second_op: got %0d active cycles want 0", extra); end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int extra;
        applyStimulus(8'h10, 8'h20, lat);
        total++; if (t8 !== 8'hF0) begin bad++; $display("[TB] FAIL midrst_pre: got %h want F0", t8); end
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h50; b8 = 8'h20;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (busy8 !== 1'b0 || done8 !== 1'b0)
            begin bad++; $display("[TB] FAIL midrst_ctrl: got busy=%b done=%b want 0/0", busy8, done8); end
        total++; if (t8 !== 8'h00 || flag8 !== 1'b0 || ovf8 !== 1'b0 || zero8 !== 1'b1)
            begin bad++; $display("[TB] FAIL midrst_outputs: got t=%h f=%b o=%b z=%b want 00/0/0/1", t8, flag8, ovf8, zero8); end
        extra = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done8 === 1'b1) extra++;
        end
        total++; if (extra != 0) begin bad++; $display("[TB] FAIL midrst_no_done: got %0d done pulses want 0", extra); end
    endtask

    task automatic test_single_step();
        int lat;
        applyStimulus16(16'h0000, 16'h0001, lat);
        total++; if (lat != 2) begin bad++; $display("[TB] FAIL single_latency: got %0d want 2", lat); end
        total++; if (t16 !== 16'hFFFF || flag16 !== 1'b1 || ovf16 !== 1'b0 || zero16 !== 1'b0)
            begin bad++; $display("[TB] FAIL single_result: got t=%h f=%b o=%b z=%b want FFFF/1/0/0", t16, flag16, ovf16, zero16); end
    endtask

    task automatic test_back_to_back();
        int   dones;
        logic prevDone;
        logic wide;
        dones = 0; prevDone = 1'b0; wide = 1'b0;
        @(negedge clk);
        start16 = 1'b1; a16 = 16'h1234; b16 = 16'h0234;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            if (c == 8) start16 = 1'b0;
            if (done16 === 1'b1) begin
                dones++;
                if (prevDone) wide = 1'b1;
            end
            prevDone = (done16 === 1'b1);
        end
        total++; if (dones != 3 || wide)
            begin bad++; $display("[TB] FAIL b2b_dones: got %0d pulses (wide=%b) want 3 single-cycle", dones, wide); end
        total++; if (t16 !== 16'h1000) begin bad++; $display("[TB] FAIL b2b_result: got %h want 1000", t16); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_enable();
        test_restart_ignored();
        test_reset_mid_run();
        test_single_step();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
